// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: job handshake, array control and row-drain signals of the systolic sequencer.
// master = job issuer / result consumer, slave = controller.
interface systolic_seq_ctrl_if #(
  parameter int N_SIZE = 4,
  parameter int K_MAX  = 16
);
  localparam int CW = $clog2(K_MAX + 2*N_SIZE - 1);
  localparam int SW = $clog2(N_SIZE);
  localparam int KW = $clog2(K_MAX + 1);
  logic          start_valid;
  logic          start_ready;
  logic [KW-1:0] k_len;
  logic          clear_acc;
  logic          array_en;
  logic [CW-1:0] count_out;
  logic          row_valid;
  logic [SW-1:0] row_sel;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err_klen;
  modport master (
    output start_valid, k_len, out_ready,
    input  start_ready, clear_acc, array_en, count_out, row_valid, row_sel, busy, done, err_klen
  );
  modport slave (
    input  start_valid, k_len, out_ready,
    output start_ready, clear_acc, array_en, count_out, row_valid, row_sel, busy, done, err_klen
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: IDLE/COMPUTE/DRAIN sequencer for an N x N systolic array.
// SYS_CTRL_BACKPRESSURE_EN: when defined, out_ready stalls row draining; otherwise one row per cycle.
module systolic_seq_ctrl #(
  parameter int N_SIZE = 4,
  parameter int K_MAX  = 16
) (
  input logic clk,
  input logic rst_n,
  systolic_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(K_MAX + 2*N_SIZE - 1);
  localparam int SW = $clog2(N_SIZE);
  localparam int KW = $clog2(K_MAX + 1);
  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;
  state_t        st;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sel;
  logic          done_q, err_q;
  logic          hs, k_ok, last_tick, take;
  assign hs        = bus.start_valid & (st == IDLE);
  assign k_ok      = (bus.k_len != '0) && (bus.k_len <= KW'(K_MAX));
  // final tick is K + 2N - 3: operands need 2N-2 extra cycles to skew through the array
  assign last_tick = cnt == CW'(k_q) + CW'(2*N_SIZE - 3);
`ifdef SYS_CTRL_BACKPRESSURE_EN
  assign take = bus.out_ready;
`else
  assign take = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      k_q    <= '0;
      cnt    <= '0;
      sel    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (st)
        IDLE: if (hs) begin
          if (k_ok) begin
            k_q <= bus.k_len;
            cnt <= '0;
            st  <= COMPUTE;
          end else err_q <= 1'b1;
        end
        COMPUTE: if (last_tick) st <= DRAIN;
                 else cnt <= cnt + CW'(1);
        DRAIN: if (take) begin
          if (sel == SW'(N_SIZE - 1)) begin
            st     <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            done_q <= 1'b1;
          end else sel <= sel + SW'(1);
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign bus.start_ready = st == IDLE;
  assign bus.clear_acc   = hs & k_ok;
  assign bus.array_en    = st == COMPUTE;
  assign bus.count_out   = cnt;
  assign bus.row_valid   = st == DRAIN;
  assign bus.row_sel     = sel;
  assign bus.busy        = st != IDLE;
  assign bus.done        = done_q;
  assign bus.err_klen    = err_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed jobs checked every cycle against a cycle-offset model of the sequencer.
module tb_systolic_seq_ctrl;
  localparam int N = 4, KM = 16;
`ifdef SYS_CTRL_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  systolic_seq_ctrl_if #(.N_SIZE(N), .K_MAX(KM)) bus();
  systolic_seq_ctrl #(.N_SIZE(N), .K_MAX(KM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, fails = 0, cyc = 0;
  bit job, idle, comp, drn, kok;
  int h, t, rows, d, done_at = -1, err_at = -1;
  int en_n, clr_n, err_n, done_n, busy_n, max_c, hs_at, dn_at;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr_stats();
    en_n = 0; clr_n = 0; err_n = 0; done_n = 0; busy_n = 0; max_c = 0; hs_at = -1; dn_at = -1;
  endtask
  task automatic start(input int k);
    clr_stats();
    bus.k_len = k;
    bus.start_valid = 1'b1;
    step(1);
    bus.start_valid = 1'b0;
  endtask
  // model: a job is (compute entry cycle h, tick total t, rows drained so far)
  always @(negedge clk) begin
    if (!rst_n) begin
      job = 1'b0; done_at = -1; err_at = -1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_array_en", bus.array_en, 0);
      chk("rst_row_valid", bus.row_valid, 0);
      chk("rst_count", bus.count_out, 0);
      chk("rst_row_sel", bus.row_sel, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err_klen, 0);
      chk("rst_clear", bus.clear_acc, 0);
    end else begin
      idle = !job;
      d    = cyc - h;
      comp = job && d < t;
      drn  = job && !comp;
      kok  = bus.k_len >= 1 && bus.k_len <= KM;
      chk("start_ready", bus.start_ready, idle);
      chk("clear_acc", bus.clear_acc, idle && bus.start_valid && kok);
      chk("array_en", bus.array_en, comp);
      chk("busy", bus.busy, job);
      chk("row_valid", bus.row_valid, drn);
      chk("row_sel", bus.row_sel, drn ? rows : 0);
      chk("count_out", bus.count_out, !job ? 0 : comp ? d : t - 1);
      chk("done", bus.done, cyc == done_at);
      chk("err_klen", bus.err_klen, cyc == err_at);
      en_n += int'(bus.array_en); clr_n += int'(bus.clear_acc); err_n += int'(bus.err_klen);
      done_n += int'(bus.done); busy_n += int'(bus.busy);
      if (int'(bus.count_out) > max_c) max_c = int'(bus.count_out);
      if (bus.done) dn_at = cyc;
      if (idle && bus.start_valid) begin
        if (kok) begin
          job = 1'b1; h = cyc + 1; t = int'(bus.k_len) + 2*N - 2; rows = 0; hs_at = cyc;
        end else err_at = cyc + 1;
      end else if (drn && (bus.out_ready || !BP)) begin
        rows++;
        if (rows == N) begin
          job = 1'b0; done_at = cyc + 1;
        end
      end
    end
    cyc++;
  end
  initial begin
    bus.start_valid = 1'b0; bus.k_len = '0; bus.out_ready = 1'b1;
    clr_stats();
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("init_ready", bus.start_ready, 1);
    chk("init_busy", bus.busy, 0);
    // k=4: 10 compute ticks, 4 drain rows, done 15 cycles after handshake
    start(4);
    step(25);
    chk("k4_en_cycles", en_n, 10);
    chk("k4_max_count", max_c, 9);
    chk("k4_clear", clr_n, 1);
    chk("k4_done_cnt", done_n, 1);
    chk("k4_busy_cycles", busy_n, 14);
    chk("k4_done_lat", dn_at - hs_at, 15);
    // k=16: 22 compute ticks
    start(16);
    step(40);
    chk("k16_en_cycles", en_n, 22);
    chk("k16_max_count", max_c, 21);
    chk("k16_done_lat", dn_at - hs_at, 27);
    // stall row 1 for three cycles
    start(4);
    step(11);
    bus.out_ready = 1'b0;
    step(2);
    #2;
    chk("stall_row_sel", bus.row_sel, BP ? 1 : 3);
    chk("stall_array_en", bus.array_en, 0);
    step(1);
    bus.out_ready = 1'b1;
    step(30);
    chk("stall_done_lat", dn_at - hs_at, BP ? 18 : 15);
    chk("stall_en_cycles", en_n, 10);
    // invalid lengths
    for (int i = 0; i < 2; i++) begin
      start(i == 0 ? 0 : 17);
      step(5);
      chk("bad_err_cnt", err_n, 1);
      chk("bad_clear", clr_n, 0);
      chk("bad_busy", busy_n, 0);
    end
    // asynchronous reset at count 5
    start(8);
    for (int i = 0; i < 30 && bus.count_out != 5; i++) step(1);
    chk("reach_count5", bus.count_out, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_array_en", bus.array_en, 0);
    chk("arst_count", bus.count_out, 0);
    chk("arst_row_valid", bus.row_valid, 0);
    step(2);
    rst_n = 1'b1;
    step(25);
    chk("arst_no_done", done_n, 0);
    start(4);
    step(25);
    chk("post_rst_done_lat", dn_at - hs_at, 15);
    chk("post_rst_done_cnt", done_n, 1);
    // back-to-back jobs: 13 cycles each (8 compute, 4 drain, 1 idle)
    clr_stats();
    bus.k_len = 2;
    bus.start_valid = 1'b1;
    step(60);
    bus.start_valid = 1'b0;
    step(20);
    chk("b2b_jobs", clr_n, 5);
    chk("b2b_done", done_n, 5);
    chk("b2b_en_cycles", en_n, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter N_SIZE, default 4: systolic array dimension (N x N PEs), N_SIZE >= 2.
REQ-002 SHALL have parameter K_MAX, default 16: maximum runtime inner dimension, K_MAX >= 1.
REQ-003 SHALL derive CW = $clog2(K_MAX + 2*N_SIZE - 1) and SW = $clog2(N_SIZE).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_valid  input  1  job request.
REQ-007 SHALL have port start_ready  output  1  controller can accept a job.
REQ-008 SHALL have port k_len  input  $clog2(K_MAX+1)  inner dimension, sampled on start handshake.
REQ-009 SHALL have port clear_acc  output  1  one-cycle PE accumulator clear.
REQ-010 SHALL have port array_en  output  1  global PE shift/accumulate enable.
REQ-011 SHALL have port count_out  output  CW  compute tick broadcast to PEs and skew feeders.
REQ-012 SHALL have port row_valid  output  1  result row presented.
REQ-013 SHALL have port row_sel  output  SW  result row index for output mux.
REQ-014 SHALL have port out_ready  input  1  downstream accepts current row.
REQ-015 SHALL have ports busy, done, err_klen  output  1 each: job in progress; one-cycle job-complete pulse; one-cycle invalid k_len pulse.

Function
REQ-016 SHALL implement FSM states IDLE, COMPUTE, DRAIN.
REQ-017 SHALL drive start_ready=1 only in IDLE; a handshake is start_valid & start_ready.
REQ-018 On handshake with 1 <= k_len <= K_MAX: latch k_len as K, pulse clear_acc same cycle, enter COMPUTE next cycle with count=0.
REQ-019 On handshake with k_len==0 or k_len>K_MAX: pulse err_klen next cycle, no clear_acc, remain IDLE.
REQ-020 In COMPUTE: array_en=1, count increments by 1 each cycle from 0; T = K + 2*N_SIZE - 2 ticks total.
REQ-021 SHALL transition COMPUTE->DRAIN when count==T-1; count holds at T-1 in DRAIN.
REQ-022 In DRAIN: array_en=0 (accumulators frozen), row_valid=1, row_sel starts at 0.
REQ-023 Row accepted when row_valid & out_ready: row_sel increments; row_sel and row_valid stable while not accepted.
REQ-024 On acceptance of row N_SIZE-1: done pulses next cycle, FSM enters IDLE, count returns to 0.
REQ-025 busy=1 in COMPUTE and DRAIN, 0 in IDLE.
REQ-026 start_valid in COMPUTE/DRAIN SHALL be ignored (not queued); new job earliest in cycle IDLE is re-entered.
REQ-027 count_out SHALL be 0 in IDLE; row_sel SHALL be 0 when row_valid=0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, count=0, row_sel=0, K=0, and all outputs to: start_ready=1 (once rst_n released), clear_acc=0, array_en=0, row_valid=0, busy=0, done=0, err_klen=0.
REQ-029 Reset mid-COMPUTE or mid-DRAIN SHALL abort the job without done pulse.

Configuration
REQ-030 Macro SYS_CTRL_BACKPRESSURE_EN: defined -> out_ready honoured per REQ-023; undefined -> out_ready ignored, one row accepted every DRAIN cycle (DRAIN lasts exactly N_SIZE cycles).

Verification
REQ-031 N=4, k_len=4, out_ready=1: clear_acc at handshake, array_en high 10 cycles (count 0..9), row_sel 0,1,2,3 on 4 cycles, done 1 cycle after row 3.
REQ-032 N=4, k_len=16: COMPUTE lasts 22 cycles, count_out reaches 21, then DRAIN.
REQ-033 BACKPRESSURE_EN, out_ready low 3 cycles during row 1: row_sel holds 1, array_en stays 0, done delayed by 3 cycles.
REQ-034 k_len=0 and k_len=17: err_klen pulses, busy stays 0, no clear_acc.
REQ-035 rst_n asserted at count=5: all outputs to reset values asynchronously, no done; next start works normally.
REQ-036 start_valid held high continuously: jobs run back-to-back, each preceded by one IDLE cycle with start_ready=1.
